// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared types and elaboration helpers for the digit-serial
// GF(2^m) multiplier.
//   state_e      - control FSM states
//   n_digits     - number of D-bit digits covering a WIDTH-bit operand
//   cnt_width    - digit counter width (at least 1 bit)
//   digit_legal  - true when a single reduction fold suffices for x^D
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int n_digits(input int width, input int d);
    return (width + d - 1) / d;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // x^D mod f is done with one fold of the overflow bits; that only works
  // when the folded bits shifted by the highest middle term stay below x^m.
  function automatic bit digit_legal(input int width, input int d, input int k3,
                                     input int k2, input int k1, input int penta);
    if (d < 1 || d > width) return 1'b0;
    if (penta != 0) return (k3 > k2) && (k2 > k1) && (k1 > 0) && (d <= width - k3);
    return (k1 > 0) && (d <= width - k1);
  endfunction

endpackage

// File: rtl/gf2m_shift_xi.sv
// gf2m_shift_xi: combinational q = en ? p*x^I mod f : 0.
// f(x) = x^WIDTH + x^K3 + x^K2 + x^K1 + 1 (PENTA=1) or x^WIDTH + x^K1 + 1.
// Valid for I <= WIDTH-K3 (PENTA=1) or I <= WIDTH-K1 (PENTA=0); I=0 is a
// plain gate.
//   en  in   1      gate; 0 forces q to zero
//   p   in   WIDTH  polynomial, bit i = coeff of x^i
//   q   out  WIDTH  reduced product
module gf2m_shift_xi #(
  parameter int WIDTH = 83,
  parameter int K3    = 7,
  parameter int K2    = 4,
  parameter int K1    = 2,
  parameter int PENTA = 1,
  parameter int I     = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lo, hi, fold;

  // lo: bits of p*x^I that stay below x^m; hi: the I bits pushed past x^m,
  // re-based to x^0 so they can be folded with x^m == f - x^m.
  assign lo = p << I;
  assign hi = p >> (WIDTH - I);

  always_comb begin
    fold = hi ^ (hi << K1);
    if (PENTA != 0) fold = fold ^ (hi << K2) ^ (hi << K3);
  end

  assign q = en ? (lo ^ fold) : '0;

endmodule

// File: rtl/gf2m_mul_digit_hs.sv
// gf2m_mul_digit_hs: digit-serial GF(2^m) multiplier, MSB digit first,
// with valid/ready handshakes and back-to-back issue from DONE.
// Optional feature macro: GF2M_MUL_ACC_EN (adds op_acc, op_c = a*b + acc).
//   clk        in   1      clock, rising edge
//   rst_b      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands accepted this cycle
//   op_a       in   WIDTH  multiplicand
//   op_b       in   WIDTH  multiplier
//   op_acc     in   WIDTH  addend (GF2M_MUL_ACC_EN only)
//   out_valid  out  1      op_c holds a result
//   out_ready  in   1      consumer takes op_c
//   op_c       out  WIDTH  a*b (+acc) mod f
//   busy       out  1      FSM not IDLE
module gf2m_mul_digit_hs
  import gf2m_pkg::*;
#(
  parameter int WIDTH = 83,
  parameter int K3    = 7,
  parameter int K2    = 4,
  parameter int K1    = 2,
  parameter int D     = 16,
  parameter int PENTA = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef GF2M_MUL_ACC_EN
  input  logic [WIDTH-1:0] op_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_c,
  output logic             busy
);

  localparam int N     = n_digits(WIDTH, D);
  localparam int AW    = N * D;
  localparam int CW    = cnt_width(N);
  localparam bit LEGAL = digit_legal(WIDTH, D, K3, K2, K1, PENTA);

  if (!LEGAL) begin : g_bad_cfg
    $error("gf2m_mul_digit_hs: D/K parameters need more than one reduction fold");
  end

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    a_q;      // a zero-padded to N*D bits, top digit consumed first
  logic [WIDTH-1:0] b_q, c_q;
  logic [D-1:0]     a_top;
  logic [D-1:0][WIDTH-1:0] pp;
  logic [WIDTH-1:0] pp_sum, c_sh, c_next, acc_term;
  logic             load, last;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign load     = in_valid && in_ready;
  assign last     = (cnt == CW'(N - 1));
  assign a_top    = a_q[AW-1 -: D];
  assign op_c     = c_q;

  // Partial products a_top[j] * b * x^j mod f, one reducer per digit bit.
  for (genvar j = 0; j < D; j++) begin : g_pp
    gf2m_shift_xi #(.WIDTH(WIDTH), .K3(K3), .K2(K2), .K1(K1), .PENTA(PENTA), .I(j))
      u_pp (.en(a_top[j]), .p(b_q), .q(pp[j]));
  end

  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < D; j++) pp_sum = pp_sum ^ pp[j];
  end

  // Horner step: shift the running result up by one digit.
  gf2m_shift_xi #(.WIDTH(WIDTH), .K3(K3), .K2(K2), .K1(K1), .PENTA(PENTA), .I(D))
    u_csh (.en(1'b1), .p(c_q), .q(c_sh));

  assign c_next = c_sh ^ pp_sum;

`ifdef GF2M_MUL_ACC_EN
  logic [WIDTH-1:0] acc_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)    acc_q <= '0;
    else if (load) acc_q <= op_acc;
  end
  assign acc_term = acc_q;
`else
  assign acc_term = '0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            // From DONE this is the back-to-back path: straight to RUN.
            a_q       <= AW'(op_a);
            b_q       <= op_b;
            c_q       <= '0;
            cnt       <= '0;
            state     <= RUN;
            out_valid <= 1'b0;
            busy      <= 1'b1;
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        RUN: begin
          c_q <= last ? (c_next ^ acc_term) : c_next;
          a_q <= a_q << D;
          if (last) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_mul_digit_hs.sv
// tb_gf2m_mul_digit_hs: randomized self-checking bench for gf2m_mul_digit_hs
// at default parameters (f = x^83 + x^7 + x^4 + x^2 + 1, D = 16, N = 6).
// Reference product is schoolbook carry-less multiply then long division by f.
module tb_gf2m_mul_digit_hs;
  localparam int W = 83;
  localparam int LAT = 7;  // cycles from handshake cycle to first out_valid cycle

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, op_acc = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] op_c;

  gf2m_mul_digit_hs dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
`ifdef GF2M_MUL_ACC_EN
    .op_acc(op_acc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .op_c(op_c), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] acc);
    logic [2*W-1:0] p, f, aw;
    p = '0; f = '0;
    f[W] = 1'b1; f[7] = 1'b1; f[4] = 1'b1; f[2] = 1'b1; f[0] = 1'b1;
    aw = {{W{1'b0}}, a};
    for (int i = 0; i < W; i++) if (b[i]) p = p ^ (aw << i);
    for (int k = 2*W-2; k >= W; k--) if (p[k]) p = p ^ (f << (k - W));
    return p[W-1:0] ^ acc;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] xp(input int e);
    logic [W-1:0] v;
    v = '0; v[e] = 1'b1;
    return v;
  endfunction

  // Drive operands until the handshake edge; returns at handshake edge + 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] acc);
    bit ok;
    ok = 0;
    op_a = a; op_b = b; op_acc = acc; in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1; ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", W'(0), W'(1));
  endtask

  // Wait for out_valid, hold it for 'stall' cycles, then consume.
  task automatic collect(input int stall, output logic [W-1:0] c, output int cyc);
    cyc = 1;
    out_ready = 1'b0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!out_valid) chk("result_timeout", W'(0), W'(1));
    in_valid = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    c = op_c;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] acc_rnd();
`ifdef GF2M_MUL_ACC_EN
    return rnd();
`else
    return '0;
`endif
  endfunction

  initial begin
    logic [W-1:0] a, b, acc, c, c0;
    logic [W-1:0] ones;
    int cyc;
    bit hold_ok;
    ones = '1;

    #12;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_op_c", op_c, W'(0));
    rst_b = 1'b1;
    @(posedge clk); #1;

    // a=1, b=0x1234, plus latency
    issue(W'(1), W'('h1234), W'(0));
    chk("run_busy", W'(busy), W'(1));
    collect(0, c, cyc);
    chk("t1_val", c, W'('h1234));
    chk("t1_latency", W'(cyc), W'(LAT));

    // a=x, b=x^82; junk on in_valid during RUN must be ignored
    issue(xp(1), xp(82), W'(0));
    op_a = rnd(); op_b = rnd(); in_valid = 1'b1;
    #1 chk("run_in_ready", W'(in_ready), W'(0));
    collect(1, c, cyc);
    chk("t2_val", c, W'('h95));

    // a=b=x^82
    issue(xp(82), xp(82), W'(0));
    collect(0, c, cyc);
    chk("t3_val", c, xp(81) ^ xp(12) ^ xp(6) ^ xp(5) ^ xp(0));
    chk("t3_model", c, ref_mul(xp(82), xp(82), W'(0)));

    // corner operands
    issue(ones, ones, W'(0));
    collect(0, c, cyc);
    chk("ones", c, ref_mul(ones, ones, W'(0)));
    issue(W'(0), ones, W'(0));
    collect(0, c, cyc);
    chk("zero_a", c, W'(0));

    // random pairs with random result-side stalls
    for (int i = 0; i < 200; i++) begin
      a = rnd(); b = rnd(); acc = acc_rnd();
      issue(a, b, acc);
      collect($urandom_range(0, 3), c, cyc);
      chk("rand", c, ref_mul(a, b, acc));
    end

    // hold DONE with out_ready=0 for 20 cycles, then back-to-back accept
    a = rnd(); b = rnd();
    issue(a, b, W'(0));
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("hold_reached", W'(out_valid), W'(1));
    c0 = op_c;
    hold_ok = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (op_c !== c0 || !out_valid || in_ready) hold_ok = 0;
    end
    chk("hold_stable", W'(hold_ok), W'(1));
    chk("hold_val", c0, ref_mul(a, b, W'(0)));
    a = rnd(); b = rnd();
    op_a = a; op_b = b; op_acc = '0; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("b2b_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_busy", W'(busy), W'(1));
    chk("b2b_out_valid", W'(out_valid), W'(0));
    chk("b2b_in_ready_run", W'(in_ready), W'(0));
    collect(0, c, cyc);
    chk("b2b_val", c, ref_mul(a, b, W'(0)));
    chk("b2b_latency", W'(cyc), W'(LAT));

    // async reset at RUN cnt=3
    issue(rnd(), rnd(), W'(0));
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_busy", W'(busy), W'(1));
    rst_b = 1'b0;
    #1;
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_op_c", op_c, W'(0));
    #2 rst_b = 1'b1;
    @(posedge clk); #1;
    a = rnd(); b = rnd();
    issue(a, b, W'(0));
    collect(0, c, cyc);
    chk("post_rst_val", c, ref_mul(a, b, W'(0)));
    chk("post_rst_latency", W'(cyc), W'(LAT));

`ifdef GF2M_MUL_ACC_EN
    issue(xp(1), xp(82), W'('h95));
    collect(0, c, cyc);
    chk("acc_cancel", c, W'(0));
    issue(W'(0), rnd(), W'(1));
    collect(0, c, cyc);
    chk("acc_only", c, W'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
